// File: rtl/pc_plus4.sv
// Registered next-sequential-PC incrementer for the RV32I fetch stage.
// Optional carry-out flag `wrap` is built in when PCPLUS4_WRAP_FLAG_EN is defined.
module pc_plus4 #(
  parameter int          XLEN = 32,
  parameter int unsigned INCR = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4
`ifdef PCPLUS4_WRAP_FLAG_EN
  ,
  output logic            wrap
`endif
);

`ifdef PCPLUS4_WRAP_FLAG_EN
  // Carry is kept as the extra top bit of the sum.
  logic [XLEN:0] sum;

  assign sum = {1'b0, pc} + (XLEN+1)'(INCR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcplus4 <= '0;
      wrap    <= 1'b0;
    end else begin
      pcplus4 <= sum[XLEN-1:0];
      wrap    <= sum[XLEN];
    end
  end
`else
  logic [XLEN-1:0] sum;

  assign sum = pc + XLEN'(INCR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcplus4 <= '0;
    end else begin
      pcplus4 <= sum;
    end
  end
`endif

endmodule

// File: tb/tb_pc_plus4.sv
// Directed self-checking bench for pc_plus4; checks wrap too when PCPLUS4_WRAP_FLAG_EN is set.
module tb_pc_plus4;
  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] pcplus4;
`ifdef PCPLUS4_WRAP_FLAG_EN
  logic        wrap;
`endif

  int checks = 0;
  int errors = 0;

  pc_plus4 #(.XLEN(32), .INCR(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pc      (pc),
    .pcplus4 (pcplus4)
`ifdef PCPLUS4_WRAP_FLAG_EN
    ,
    .wrap    (wrap)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step past the next rising edge so outputs are sampled away from it.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pc    = 32'h1234_5678;
    #1;
    for (int i = 0; i < 3; i++) begin
      after_edge();
      checks++;
      if (pcplus4 !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: pcplus4=%h expected=%h", i, pcplus4, 32'h0);
      end
`ifdef PCPLUS4_WRAP_FLAG_EN
      checks++;
      if (wrap !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_wrap cyc%0d: wrap=%b expected=0", i, wrap);
      end
`endif
    end
    @(negedge clk);
    rst_n = 1'b1;
    pc    = 32'h0;
  endtask

  task automatic test_basic();
    logic [31:0] vin [3];
    logic [31:0] vexp[3];
    vin[0] = 32'h0000_0000; vexp[0] = 32'h0000_0004;
    vin[1] = 32'h0000_0001; vexp[1] = 32'h0000_0005;
    vin[2] = 32'h0000_00FF; vexp[2] = 32'h0000_0103;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc = vin[i];
      after_edge();
      checks++;
      if (pcplus4 !== vexp[i]) begin
        errors++;
        $display("FAIL basic pc=%h: pcplus4=%h expected=%h", vin[i], pcplus4, vexp[i]);
      end
`ifdef PCPLUS4_WRAP_FLAG_EN
      checks++;
      if (wrap !== 1'b0) begin
        errors++;
        $display("FAIL basic_wrap pc=%h: wrap=%b expected=0", vin[i], wrap);
      end
`endif
      after_edge();
      checks++;
      if (pcplus4 !== vexp[i]) begin
        errors++;
        $display("FAIL basic_hold pc=%h: pcplus4=%h expected=%h", vin[i], pcplus4, vexp[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] vin [3];
    logic [31:0] vexp[3];
    logic        wexp[3];
    vin[0] = 32'hFFFF_FFFF; vexp[0] = 32'h0000_0003; wexp[0] = 1'b1;
    vin[1] = 32'hFFFF_FFFC; vexp[1] = 32'h0000_0000; wexp[1] = 1'b1;
    vin[2] = 32'hFFFF_FFFB; vexp[2] = 32'hFFFF_FFFF; wexp[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc = vin[i];
      after_edge();
      checks++;
      if (pcplus4 !== vexp[i]) begin
        errors++;
        $display("FAIL wrap_sum pc=%h: pcplus4=%h expected=%h", vin[i], pcplus4, vexp[i]);
      end
`ifdef PCPLUS4_WRAP_FLAG_EN
      checks++;
      if (wrap !== wexp[i]) begin
        errors++;
        $display("FAIL wrap_flag pc=%h: wrap=%b expected=%b", vin[i], wrap, wexp[i]);
      end
`else
      if (wexp[i] === 1'bx) $display("unreachable");
`endif
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    pc = 32'h10;
    after_edge();
    checks++;
    if (pcplus4 !== 32'h14) begin
      errors++;
      $display("FAIL latency_first: pcplus4=%h expected=%h", pcplus4, 32'h14);
    end
    @(negedge clk);
    pc = 32'h20;
    #2;
    checks++;
    if (pcplus4 !== 32'h14) begin
      errors++;
      $display("FAIL latency_midcycle: pcplus4=%h expected=%h", pcplus4, 32'h14);
    end
    after_edge();
    checks++;
    if (pcplus4 !== 32'h24) begin
      errors++;
      $display("FAIL latency_next_edge: pcplus4=%h expected=%h", pcplus4, 32'h24);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin [5];
    logic [31:0] vexp[5];
    vin[0] = 32'h0000_1000; vexp[0] = 32'h0000_1004;
    vin[1] = 32'h0000_1004; vexp[1] = 32'h0000_1008;
    vin[2] = 32'h8000_0002; vexp[2] = 32'h8000_0006;
    vin[3] = 32'h7FFF_FFFE; vexp[3] = 32'h8000_0002;
    vin[4] = 32'hDEAD_BEEF; vexp[4] = 32'hDEAD_BEF3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pc = vin[i];
      if (i > 0) begin
        #1;
        checks++;
        if (pcplus4 !== vexp[i-1]) begin
          errors++;
          $display("FAIL b2b_lag idx%0d: pcplus4=%h expected=%h", i, pcplus4, vexp[i-1]);
        end
      end
      after_edge();
      checks++;
      if (pcplus4 !== vexp[i]) begin
        errors++;
        $display("FAIL b2b idx%0d: pcplus4=%h expected=%h", i, pcplus4, vexp[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    pc = 32'hFFFF_FFFF;
    after_edge();
    checks++;
    if (pcplus4 !== 32'h3) begin
      errors++;
      $display("FAIL async_preload: pcplus4=%h expected=%h", pcplus4, 32'h3);
    end
    pc = 32'h0000_0100;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pcplus4 !== 32'h0) begin
      errors++;
      $display("FAIL async_clear: pcplus4=%h expected=%h", pcplus4, 32'h0);
    end
`ifdef PCPLUS4_WRAP_FLAG_EN
    checks++;
    if (wrap !== 1'b0) begin
      errors++;
      $display("FAIL async_clear_wrap: wrap=%b expected=0", wrap);
    end
`endif
    after_edge();
    checks++;
    if (pcplus4 !== 32'h0) begin
      errors++;
      $display("FAIL async_edge_ignored: pcplus4=%h expected=%h", pcplus4, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pc    = 32'h0000_0200;
    after_edge();
    checks++;
    if (pcplus4 !== 32'h204) begin
      errors++;
      $display("FAIL async_release: pcplus4=%h expected=%h", pcplus4, 32'h204);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pc    = 32'h0;
    test_reset();
    test_basic();
    test_wrap();
    test_latency();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
